// File: rtl/param_sync_pkg.sv
// rtl/param_sync_pkg.sv - shared constants and types for the discharge-parameter sync bank
package param_sync_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NUM_CH_DEF = 4;

    localparam int CH_TON  = 0;
    localparam int CH_TOFF = 1;
    localparam int CH_IP   = 2;
    localparam int CH_WAVE = 3;

    localparam logic [NUM_CH_DEF*DATA_W_DEF-1:0] RST_VAL_DEF =
        {16'h0000, 16'd0, 16'd100, 16'd0};

    typedef enum logic {
        SED_TOGGLE = 1'b0,
        SED_RISE   = 1'b1
    } sed_mode_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with toggle or rising-edge detect
module sync_edge_det
    import param_sync_pkg::*;
#(
    parameter int        SYNC_STAGES = 3,
    parameter sed_mode_e MODE        = SED_TOGGLE
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   seen_q;
    logic                   seen_d;

    // seen tracks the last consumed synchronised level, one stage behind the chain output
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        seen_d = sync_q[SYNC_STAGES-1];
        if (MODE == SED_TOGGLE) begin
            edge_out = sync_q[SYNC_STAGES-1] ^ seen_q;
        end else begin
            edge_out = sync_q[SYNC_STAGES-1] & ~seen_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            seen_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/param_sync_bank.sv
// rtl/param_sync_bank.sv - CDC bank carrying SPI parameter updates into clk with optional atomic commit
module param_sync_bank
    import param_sync_pkg::*;
#(
    parameter int                         NUM_CH      = NUM_CH_DEF,
    parameter int                         DATA_W      = DATA_W_DEF,
    parameter int                         SYNC_STAGES = 3,
    parameter logic [NUM_CH*DATA_W-1:0]   RST_VAL     = RST_VAL_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_tgl_async,
    input  logic [NUM_CH*DATA_W-1:0] data_async,
    output logic [NUM_CH-1:0]        ack_tgl,
    input  logic                     commit_mode,
    input  logic                     commit_stb,
    output logic [NUM_CH*DATA_W-1:0] active_data,
    output logic [NUM_CH-1:0]        pending,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     overrun_clr,
    output logic                     update_pulse,
    input  logic                     start_req_async,
    input  logic                     stop_req_async,
    output logic                     is_machine_spi
);

    logic [NUM_CH-1:0]        req_det;
    logic                     start_rise;
    logic                     stop_rise;

    logic [NUM_CH*DATA_W-1:0] active_q, active_d;
    logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0]        ack_q, ack_d;
    logic [NUM_CH-1:0]        pending_q, pending_d;
    logic [NUM_CH-1:0]        overrun_q, overrun_d;
    logic                     update_pulse_q, update_pulse_d;
    logic                     run_q, run_d;
    logic [NUM_CH-1:0]        load;
    logic                     commit_go;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        sync_edge_det #(
            .SYNC_STAGES (SYNC_STAGES),
            .MODE        (SED_TOGGLE)
        ) u_req_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (req_tgl_async[gi]),
            .edge_out (req_det[gi])
        );
    end

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .MODE        (SED_RISE)
    ) u_start_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (start_req_async),
        .edge_out (start_rise)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .MODE        (SED_RISE)
    ) u_stop_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (stop_req_async),
        .edge_out (stop_rise)
    );

    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        ack_d     = ack_q;
        pending_d = pending_q;
        overrun_d = overrun_clr ? '0 : overrun_q;
        load      = '0;
        // leaving deferred mode flushes pending channels like a commit strobe
        commit_go = commit_stb | ~commit_mode;

        for (int c = 0; c < NUM_CH; c++) begin
            // commit uses the pre-edge shadow, so a coincident capture is not committed
            if (commit_go && pending_q[c]) begin
                active_d[c*DATA_W +: DATA_W] = shadow_q[c*DATA_W +: DATA_W];
                pending_d[c] = 1'b0;
                load[c]      = 1'b1;
            end
            if (req_det[c]) begin
                shadow_d[c*DATA_W +: DATA_W] = data_async[c*DATA_W +: DATA_W];
                ack_d[c] = ~ack_q[c];
                if (!commit_mode) begin
                    active_d[c*DATA_W +: DATA_W] = data_async[c*DATA_W +: DATA_W];
                    load[c] = 1'b1;
                end else begin
                    if (pending_q[c] && !commit_stb) begin
                        overrun_d[c] = 1'b1;
                    end
                    pending_d[c] = 1'b1;
                end
            end
        end

        update_pulse_d = |load;

        run_d = run_q;
        if (start_rise) begin
            run_d = 1'b1;
        end
        if (stop_rise) begin
            run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q       <= RST_VAL;
            shadow_q       <= RST_VAL;
            ack_q          <= '0;
            pending_q      <= '0;
            overrun_q      <= '0;
            update_pulse_q <= 1'b0;
            run_q          <= 1'b0;
        end else begin
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            ack_q          <= ack_d;
            pending_q      <= pending_d;
            overrun_q      <= overrun_d;
            update_pulse_q <= update_pulse_d;
            run_q          <= run_d;
        end
    end

    assign active_data    = active_q;
    assign ack_tgl        = ack_q;
    assign pending        = pending_q;
    assign overrun        = overrun_q;
    assign update_pulse   = update_pulse_q;
    assign is_machine_spi = run_q;

endmodule

// File: tb/tb_param_sync_bank.sv
// tb/tb_param_sync_bank.sv - randomized self-checking bench for param_sync_bank against a behavioural model
module tb_param_sync_bank;
    import param_sync_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int S      = 3;
    localparam int W      = NUM_CH*DATA_W;
    localparam logic [W-1:0] EXP_RST = 64'h0000_0000_0064_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [NUM_CH-1:0] req_tgl_async;
    logic [W-1:0]  data_async;
    logic [NUM_CH-1:0] ack_tgl;
    logic          commit_mode;
    logic          commit_stb;
    logic [W-1:0]  active_data;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overrun;
    logic          overrun_clr;
    logic          update_pulse;
    logic          start_req_async;
    logic          stop_req_async;
    logic          is_machine_spi;

    always #5 clk = ~clk;

    param_sync_bank #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (S),
        .RST_VAL     (RST_VAL_DEF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_tgl_async   (req_tgl_async),
        .data_async      (data_async),
        .ack_tgl         (ack_tgl),
        .commit_mode     (commit_mode),
        .commit_stb      (commit_stb),
        .active_data     (active_data),
        .pending         (pending),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr),
        .update_pulse    (update_pulse),
        .start_req_async (start_req_async),
        .stop_req_async  (stop_req_async),
        .is_machine_spi  (is_machine_spi)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // behavioural reference: per-channel registers plus a delay line for the synchroniser latency
    logic [DATA_W-1:0] m_active [NUM_CH];
    logic [DATA_W-1:0] m_shadow [NUM_CH];
    logic [NUM_CH-1:0] m_pending, m_overrun, m_ack, m_seen;
    logic              m_upd, m_run, m_start_seen, m_stop_seen;
    logic [NUM_CH+1:0] m_pipe [S];

    task automatic model_reset();
        m_active  = '{16'd0, 16'd100, 16'd0, 16'd0};
        m_shadow  = '{16'd0, 16'd100, 16'd0, 16'd0};
        m_pending = '0;
        m_overrun = '0;
        m_ack     = '0;
        m_seen    = '0;
        m_upd     = 1'b0;
        m_run     = 1'b0;
        m_start_seen = 1'b0;
        m_stop_seen  = 1'b0;
        for (int i = 0; i < S; i++) m_pipe[i] = '0;
    endtask

    task automatic model_edge();
        logic [NUM_CH+1:0] old;
        logic pend0, commit_now, st, sp;
        old = m_pipe[0];
        for (int i = 0; i < S-1; i++) m_pipe[i] = m_pipe[i+1];
        m_pipe[S-1] = {stop_req_async, start_req_async, req_tgl_async};
        m_upd = 1'b0;
        if (overrun_clr) m_overrun = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pend0      = m_pending[c];
            commit_now = pend0 && (commit_stb || !commit_mode);
            if (commit_now) begin
                m_active[c]  = m_shadow[c];
                m_pending[c] = 1'b0;
                m_upd        = 1'b1;
            end
            if (old[c] != m_seen[c]) begin
                m_seen[c] = old[c];
                m_ack[c]  = ~m_ack[c];
                if (!commit_mode) begin
                    m_active[c] = data_async[c*DATA_W +: DATA_W];
                    m_upd       = 1'b1;
                end else begin
                    if (pend0 && !commit_now) m_overrun[c] = 1'b1;
                    m_pending[c] = 1'b1;
                end
                m_shadow[c] = data_async[c*DATA_W +: DATA_W];
            end
        end
        st = old[NUM_CH] & ~m_start_seen;
        sp = old[NUM_CH+1] & ~m_stop_seen;
        m_start_seen = old[NUM_CH];
        m_stop_seen  = old[NUM_CH+1];
        if (st) m_run = 1'b1;
        if (sp) m_run = 1'b0;
    endtask

    function automatic logic [W-1:0] m_active_vec();
        logic [W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = m_active[c];
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] act(input int c);
        return active_data[c*DATA_W +: DATA_W];
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("active_data", active_data, m_active_vec());
            chk("ack_tgl", W'(ack_tgl), W'(m_ack));
            chk("pending", W'(pending), W'(m_pending));
            chk("overrun", W'(overrun), W'(m_overrun));
            chk("update_pulse", W'(update_pulse), W'(m_upd));
            chk("is_machine_spi", W'(is_machine_spi), W'(m_run));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [DATA_W-1:0] v);
        data_async[c*DATA_W +: DATA_W] = v;
        req_tgl_async[c] = ~req_tgl_async[c];
    endtask

    task automatic wait_ack(input int c);
        int n;
        n = 0;
        while (ack_tgl[c] != req_tgl_async[c] && n < 20) begin
            step();
            n++;
        end
        chk("ack_wait", W'(ack_tgl[c]), W'(req_tgl_async[c]));
    endtask

    task automatic pulse_commit();
        commit_stb = 1'b1;
        step();
        commit_stb = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_tgl_async = '0;
        data_async = '0;
        commit_mode = 1'b0;
        commit_stb = 1'b0;
        overrun_clr = 1'b0;
        start_req_async = 1'b0;
        stop_req_async = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;
        rst = 1'b0;
        step();
        chk("rst_active", active_data, EXP_RST);
        chk("rst_ack", W'(ack_tgl), W'(4'b0000));
        chk("rst_run", W'(is_machine_spi), W'(1'b0));
        chk("rst_upd", W'(update_pulse), W'(1'b0));

        send(CH_TON, 16'd250);
        wait_ack(CH_TON);
        chk("m0_ton250", W'(act(CH_TON)), W'(16'd250));
        chk("m0_ack1", W'(ack_tgl[CH_TON]), W'(1'b1));
        chk("m0_upd_hi", W'(update_pulse), W'(1'b1));
        step();
        chk("m0_upd_lo", W'(update_pulse), W'(1'b0));
        send(CH_TON, 16'd300);
        wait_ack(CH_TON);
        chk("m0_ton300", W'(act(CH_TON)), W'(16'd300));
        chk("m0_ack0", W'(ack_tgl[CH_TON]), W'(1'b0));

        commit_mode = 1'b1;
        send(CH_TON, 16'd40);
        send(CH_IP, 16'd7);
        wait_ack(CH_TON);
        wait_ack(CH_IP);
        chk("m1_pending", W'(pending), W'(4'b0101));
        chk("m1_ton_held", W'(act(CH_TON)), W'(16'd300));
        pulse_commit();
        chk("m1_ton40", W'(act(CH_TON)), W'(16'd40));
        chk("m1_ip7", W'(act(CH_IP)), W'(16'd7));
        chk("m1_pend_clr", W'(pending), W'(4'b0000));
        chk("m1_upd", W'(update_pulse), W'(1'b1));
        pulse_commit();
        chk("m1_empty_commit", W'(update_pulse), W'(1'b0));

        send(CH_TOFF, 16'd50);
        wait_ack(CH_TOFF);
        send(CH_TOFF, 16'd60);
        wait_ack(CH_TOFF);
        chk("ovr_set", W'(overrun), W'(4'b0010));
        pulse_commit();
        chk("ovr_toff60", W'(act(CH_TOFF)), W'(16'd60));
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", W'(overrun), W'(4'b0000));

        send(CH_TON, 16'd80);
        wait_ack(CH_TON);
        send(CH_TON, 16'd90);
        repeat (S) step();
        pulse_commit();
        chk("coin_ton80", W'(act(CH_TON)), W'(16'd80));
        chk("coin_pend", W'(pending[CH_TON]), W'(1'b1));
        chk("coin_ovr", W'(overrun[CH_TON]), W'(1'b0));
        chk("coin_ack", W'(ack_tgl[CH_TON]), W'(req_tgl_async[CH_TON]));
        pulse_commit();
        chk("coin_ton90", W'(act(CH_TON)), W'(16'd90));

        send(CH_IP, 16'd55);
        wait_ack(CH_IP);
        commit_mode = 1'b0;
        step();
        chk("sw_ip55", W'(act(CH_IP)), W'(16'd55));
        chk("sw_pend", W'(pending), W'(4'b0000));

        start_req_async = 1'b1;
        repeat (S) step();
        chk("start_early", W'(is_machine_spi), W'(1'b0));
        step();
        chk("start_set", W'(is_machine_spi), W'(1'b1));
        start_req_async = 1'b0;
        repeat (S+2) step();
        start_req_async = 1'b1;
        stop_req_async = 1'b1;
        repeat (S+2) step();
        chk("both_stop_wins", W'(is_machine_spi), W'(1'b0));
        start_req_async = 1'b0;
        stop_req_async = 1'b0;
        start_req_async = 1'b1;
        repeat (S+2) step();
        start_req_async = 1'b0;

        send(CH_WAVE, 16'd1234);
        step();
        rst = 1'b1;
        req_tgl_async = '0;
        step();
        chk("mid_rst_active", active_data, EXP_RST);
        chk("mid_rst_ack", W'(ack_tgl), W'(4'b0000));
        chk("mid_rst_run", W'(is_machine_spi), W'(1'b0));
        chk("mid_rst_pend", W'(pending), W'(4'b0000));
        rst = 1'b0;
        repeat (S+3) step();
        chk("post_rst_ack", W'(ack_tgl), W'(4'b0000));
        chk("post_rst_wave", W'(act(CH_WAVE)), W'(16'd0));

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                rst = 1'b1;
                req_tgl_async = '0;
            end
            if (i == 704) rst = 1'b0;
            if (!rst) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ack_tgl[c] == req_tgl_async[c] && $urandom_range(3) == 0)
                        send(c, DATA_W'($urandom));
                end
            end
            commit_stb  = ($urandom_range(5) == 0);
            overrun_clr = ($urandom_range(19) == 0);
            if ($urandom_range(99) == 0) commit_mode = ~commit_mode;
            if ($urandom_range(15) == 0) start_req_async = ~start_req_async;
            if ($urandom_range(15) == 0) stop_req_async = ~stop_req_async;
            step();
        end
        commit_stb = 1'b0;
        overrun_clr = 1'b0;
        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
